// File: rtl/inst_fetch.sv
// Instruction fetch: reads four bytes from an 8-bit synchronous RAM and assembles one
// little-endian 32-bit instruction, with stall (rdy_in), flush and output backpressure.
module inst_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid_in,
  output logic              pc_ready_out,
  input  logic              flush_in,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic              mem_rd_out,
  input  logic [7:0]        mem_din_in,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc_out,
  output logic              inst_valid_out,
  input  logic              inst_ready_in,
  output logic [1:0]        state_dbg_out
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1
  // and rdy_in is 1; flush_in (with rdy_in) overrides both pc and instruction transfers.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic                mem_rd_q, mem_rd_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [1:0]          lane;

  assign pc_ready_out   = (state_q == IDLE) && rdy_in && !flush_in;
  assign mem_rd_out     = mem_rd_q && rdy_in;
  assign mem_a_out      = mem_a_q;
  assign inst_out       = inst_q;
  assign inst_pc_out    = pc_q;
  assign inst_valid_out = valid_q;
  assign state_dbg_out  = state_q;

  // Data on mem_din_in belongs to the address issued one active cycle earlier.
  assign lane = cnt_q - 2'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_a_d  = mem_a_q;
    mem_rd_d = mem_rd_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d  = IDLE;
        cnt_d    = 2'd0;
        mem_rd_d = 1'b0;
        valid_d  = 1'b0;
        inst_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (pc_valid_in) begin
              state_d  = ISSUE;
              cnt_d    = 2'd0;
              mem_a_d  = pc_in;
              mem_rd_d = 1'b1;
              inst_d   = '0;
              pc_d     = pc_in;
            end
          end
          ISSUE: begin
            if (cnt_q != 2'd0) inst_d[{lane, 3'b000} +: 8] = mem_din_in;
            if (cnt_q == 2'd3) begin
              state_d  = DRAIN;
              mem_rd_d = 1'b0;
            end else begin
              mem_a_d = mem_a_q + ADDR_W'(1);
              cnt_d   = cnt_q + 2'd1;
            end
          end
          DRAIN: begin
            inst_d[INST_W-1 -: 8] = mem_din_in;
            state_d = HOLD;
            valid_d = 1'b1;
            cnt_d   = 2'd0;
          end
          HOLD: begin
            if (inst_ready_in) begin
              state_d = IDLE;
              valid_d = 1'b0;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      mem_a_q  <= '0;
      mem_rd_q <= 1'b0;
      inst_q   <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_a_q  <= mem_a_d;
      mem_rd_q <= mem_rd_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_W, default 32, width of the byte-address and PC buses.
REQ-002 Parameter INST_W, fixed at 32, width of one instruction (4 bytes).
REQ-003 clk_in  input  1  single clock; all state changes on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous and active-low.
REQ-005 rdy_in  input  1  global ready; low freezes the block.
REQ-006 pc_in  input  ADDR_W  fetch address from the PC stage.
REQ-007 pc_valid_in  input  1  pc_in holds a new fetch request.
REQ-008 pc_ready_out  output  1  the block accepts pc_in this cycle.
REQ-009 flush_in  input  1  redirect; abort the current fetch and drop any held instruction.
REQ-010 mem_a_out  output  ADDR_W  byte address to the 8-bit synchronous RAM.
REQ-011 mem_rd_out  output  1  read strobe qualifying mem_a_out.
REQ-012 mem_din_in  input  8  RAM read data, valid exactly 1 cycle after its address.
REQ-013 inst_out  output  32  assembled instruction to IF_ID.
REQ-014 inst_pc_out  output  ADDR_W  address of inst_out.
REQ-015 inst_valid_out  output  1  inst_out/inst_pc_out valid.
REQ-016 inst_ready_in  input  1  IF_ID consumes the instruction.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, DRAIN and HOLD.
REQ-018 pc_ready_out SHALL be 1 only in IDLE with rdy_in=1 and flush_in=0 (combinational).
REQ-019 Accept: in IDLE, pc_valid_in & pc_ready_out at edge T SHALL latch pc_in as base, clear byte counters, and enter ISSUE.
REQ-020 ISSUE SHALL drive mem_rd_out=1 and mem_a_out=base+k for k=0,1,2,3 on 4 consecutive active cycles, then enter DRAIN.
REQ-021 Address arithmetic SHALL be modulo 2^ADDR_W; base=FFFF_FFFE fetches FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
REQ-022 The byte returned for address base+k SHALL be sampled 1 active cycle after issue into inst bits [8k+7:8k] (little-endian).
REQ-023 DRAIN SHALL drive mem_rd_out=0, sample the final byte, and enter HOLD.
REQ-024 Latency: with rdy_in=1 throughout, inst_valid_out SHALL rise in the 6th cycle after the accepting edge (addresses in cycles 1-4, data sampled at ends of cycles 2-5).
REQ-025 HOLD SHALL assert inst_valid_out=1, inst_pc_out=base, and keep inst_out/inst_pc_out stable until inst_ready_in=1.
REQ-026 A HOLD edge with inst_ready_in=1 SHALL deassert inst_valid_out and return to IDLE; back-to-back accept is earliest the following cycle.
REQ-027 mem_rd_out SHALL be 0 in IDLE, DRAIN and HOLD; mem_a_out holds its last value when mem_rd_out=0.
REQ-028 Misaligned base addresses SHALL be fetched without fault or correction.
REQ-029 rdy_in=0 SHALL freeze state, counters, the assembly register and all outputs; mem_rd_out SHALL be 0 while frozen, and the in-flight byte SHALL be sampled only on the next active cycle (the RAM is held by the same rdy_in).
REQ-030 flush_in=1 at an active edge SHALL, from any state, force IDLE, mem_rd_out=0 and inst_valid_out=0 next cycle, and discard partial bytes.
REQ-031 flush_in SHALL take priority over a simultaneous pc_valid_in (no accept) and a simultaneous inst_ready_in (no handshake counted).
REQ-032 flush_in SHALL be honoured only when rdy_in=1.

Reset
REQ-033 rst_in=0 SHALL immediately, without a clock edge, force IDLE, inst_out=0, inst_pc_out=0, inst_valid_out=0, mem_rd_out=0, mem_a_out=0, and clear counters.
REQ-034 Reset asserted mid-fetch SHALL abort it; after release the block SHALL wait in IDLE for a new pc_valid_in.

Verification
REQ-035 Basic: RAM[0x100..0x103]=13,05,50,00, accept pc_in=0x100 -> mem_a_out 0x100..0x103 in cycles 1-4; inst_out=0x00500513, inst_pc_out=0x100, valid in cycle 6.
REQ-036 Backpressure: inst_ready_in=0 for 5 cycles -> inst_valid_out stays 1 with unchanged outputs; pc_ready_out=0 until the handshake edge.
REQ-037 Stall: rdy_in=0 for 3 cycles after the 2nd issue -> mem_a_out holds 0x101, no address skipped or repeated; valid in cycle 9 with the correct word.
REQ-038 Flush: flush_in=1 in cycle 3 with pc_valid_in=1 -> IDLE next cycle, no valid output; the next fetch of 0x200 returns the fresh word with no stale bytes.
REQ-039 Wrap: pc_in=0xFFFF_FFFE -> addresses FFFF_FFFE, FFFF_FFFF, 0, 1; inst_pc_out=0xFFFF_FFFE.
REQ-040 Async reset: rst_in low mid-cycle during ISSUE -> outputs zero before the next edge; the fetch after release is correct.
